// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It issues sequential fetch requests to an
// instruction memory, keeps at most one request in flight, and buffers the
// returned instructions (with their PCs) in a small first-word-fall-through
// queue for the decode stage. A taken redirect (jump or resolved branch)
// flushes the queue and restarts fetch at the redirect target. If the redirect
// lands while a request is in flight, the stale response is dropped.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (XLEN)
//   imem_ready   in   memory accepts the request this cycle
//   imem_rvalid  in   response valid
//   imem_rdata   in   response instruction (ILEN)
//   pc_write     in   unconditional redirect
//   br_beq       in   redirect when alu_zero
//   br_bne       in   redirect when !alu_zero
//   alu_zero     in   ALU zero flag
//   redirect_pc  in   redirect target (XLEN), low two bits ignored
//   inst_valid   out  queue head valid
//   inst         out  head instruction (ILEN)
//   inst_pc      out  head PC (XLEN)
//   inst_ready   in   consumer pops the head
//   occupancy    out  buffered entry count ($clog2(DEPTH)+1)
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [XLEN-1:0]          imem_addr,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [ILEN-1:0]          imem_rdata,
   input  logic                     pc_write,
   input  logic                     br_beq,
   input  logic                     br_bne,
   input  logic                     alu_zero,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     inst_valid,
   output logic [ILEN-1:0]          inst,
   output logic [XLEN-1:0]          inst_pc,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   // RUN : may issue a request
   // WAIT: one request in flight, its response is kept
   // DROP: one request in flight, its response is discarded (redirected)
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_req_pc;     // PC of the request in flight

   logic [ILEN-1:0]   r_inst_mem [DEPTH];
   logic [XLEN-1:0]   r_pc_mem   [DEPTH];
   logic [AW-1:0]     r_head;
   logic [AW-1:0]     r_tail;
   logic [AW:0]       r_occ;

   logic              w_redirect;
   logic              w_full;
   logic              w_req;
   logic              w_hs;
   logic              w_push;
   logic              w_pop;
   logic              w_unused;

   // Instruction addresses are word aligned; the low target bits are dropped.
   assign w_unused   = ^redirect_pc[1:0];

   assign w_redirect = pc_write | (br_beq & alu_zero) | (br_bne & ~alu_zero);
   assign w_full     = (r_occ == (AW+1)'(DEPTH));

   // ---------------------------------------------------------------------------
   // Fetch FSM: next state, request and push decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_req        = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         RUN: begin
            // A redirect cycle never issues: the address would be stale.
            w_req = ~w_full & ~w_redirect;
            if (w_req && imem_ready)
               w_next_state = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_push       = ~w_redirect;
               w_next_state = RUN;
            end else if (w_redirect) begin
               w_next_state = DROP;
            end
         end
         DROP: begin
            if (imem_rvalid)
               w_next_state = RUN;
         end
         default: w_next_state = RUN;
      endcase
   end

   assign w_hs       = w_req & imem_ready & ~reset;
   assign imem_req   = w_req & ~reset;
   assign imem_addr  = r_fetch_pc;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= RUN;
      else
         r_state <= w_next_state;
   end

   // ---------------------------------------------------------------------------
   // Fetch PC. Redirect and handshake are exclusive (no request on redirect).
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
      end else begin
         if (w_redirect)
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         else if (w_hs)
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         if (w_hs)
            r_req_pc <= r_fetch_pc;
      end
   end

   // ---------------------------------------------------------------------------
   // Instruction queue (first-word-fall-through)
   // ---------------------------------------------------------------------------
   assign inst_valid = (r_occ != '0) & ~reset;
   assign inst       = r_inst_mem[r_head];
   assign inst_pc    = r_pc_mem[r_head];
   assign occupancy  = r_occ;
   assign w_pop      = inst_valid & inst_ready;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst_mem[r_tail] <= imem_rdata;
         r_pc_mem[r_tail]   <= r_req_pc;
      end
   end

   // A push only follows a request issued while not full, so a push never
   // meets a full queue.
   always_ff @(posedge clk) begin
      if (reset || w_redirect) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push)
            r_tail <= r_tail + AW'(1);
         if (w_pop)
            r_head <= r_head + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + (AW+1)'(1);
            2'b01:   r_occ <= r_occ - (AW+1)'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the PC and address width.
REQ-002 The block SHALL have parameter ILEN, default 32, giving the instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the instruction buffer entries (power of two, >=2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, giving the PC loaded at reset.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have port imem_req  out  1  fetch request valid.
REQ-008 The block SHALL have port imem_addr  out  XLEN  fetch address.
REQ-009 The block SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-010 The block SHALL have port imem_rvalid  in  1  response data valid.
REQ-011 The block SHALL have port imem_rdata  in  ILEN  response instruction.
REQ-012 The block SHALL have port pc_write  in  1  unconditional redirect.
REQ-013 The block SHALL have port br_beq  in  1  redirect if alu_zero.
REQ-014 The block SHALL have port br_bne  in  1  redirect if !alu_zero.
REQ-015 The block SHALL have port alu_zero  in  1  ALU zero flag.
REQ-016 The block SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-017 The block SHALL have port inst_valid  out  1  buffer head valid.
REQ-018 The block SHALL have port inst  out  ILEN  head instruction.
REQ-019 The block SHALL have port inst_pc  out  XLEN  head PC.
REQ-020 The block SHALL have port inst_ready  in  1  consumer pops the head.
REQ-021 The block SHALL have port occupancy  out  $clog2(DEPTH)+1  buffered entry count.

Function
REQ-022 redirect SHALL equal pc_write | (br_beq & alu_zero) | (br_bne & !alu_zero), combinationally.
REQ-023 The block SHALL use states RUN, WAIT and DROP, with at most one outstanding memory request.
REQ-024 In RUN, imem_req SHALL be 1 iff occupancy < DEPTH and redirect=0; imem_addr SHALL equal fetch_pc.
REQ-025 The handshake SHALL be imem_req & imem_ready; on it fetch_pc += 4 (mod 2^XLEN), the issued PC is latched and the state goes to WAIT.
REQ-026 In WAIT, imem_req SHALL be 0; on imem_rvalid, {imem_rdata, latched PC} SHALL be pushed at the tail and the state goes to RUN.
REQ-027 imem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-028 The buffer SHALL be first-word-fall-through: inst_valid = (occupancy != 0), and inst/inst_pc = head entry with no added latency.
REQ-029 A pop SHALL occur iff inst_valid & inst_ready; pop with inst_valid=0 SHALL have no effect.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-031 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-032 A redirect SHALL flush the buffer in the same edge (occupancy <= 0), regardless of any same-cycle pop or push.
REQ-033 A redirect SHALL set fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-034 Redirect in RUN SHALL stay in RUN; no request is issued that cycle.
REQ-035 Redirect in WAIT without imem_rvalid SHALL go to DROP.
REQ-036 Redirect in WAIT with imem_rvalid SHALL discard the data and go to RUN.
REQ-037 Redirect in DROP SHALL stay in DROP and update fetch_pc.
REQ-038 In DROP, imem_rvalid SHALL discard the data and go to RUN; imem_req SHALL be 0 in DROP.
REQ-039 Instructions SHALL be delivered in fetch-address order; no entry is ever lost or duplicated without a redirect.

Reset
REQ-040 While reset=1 at a rising edge, the block SHALL load fetch_pc=RESET_PC, state=RUN, occupancy=0 and pointers=0.
REQ-041 After reset, inst_valid=0 and imem_req=0 SHALL hold for the cycle in which reset is high.
REQ-042 Reset SHALL take priority over redirect, handshake and rvalid.
REQ-043 A response arriving after a mid-WAIT reset SHALL be ignored.

Verification
REQ-044 Reset, imem_ready=1, 1-cycle rvalid, inst_ready=1 -> imem_addr 0,4,8,... each fetch delivered with matching inst_pc; occupancy never exceeds 1.
REQ-045 inst_ready=0, memory always responding -> exactly 4 entries (PCs 0,4,8,12) buffered, occupancy=4, imem_req=0 until a pop; then fetch resumes at PC 16.
REQ-046 br_beq=1, alu_zero=1, redirect_pc=0x103 while in WAIT -> DROP; the next rvalid data is discarded, and the next request is at 0x100 with occupancy=0.
REQ-047 br_bne=1, alu_zero=1 -> no redirect and fetch continues sequentially; br_bne=1, alu_zero=0 -> flush and redirect.
REQ-048 XLEN=32, fetch_pc=0xFFFFFFFC -> next address 0x00000000; simultaneous push and pop at occupancy 2 -> occupancy stays 2.
REQ-049 Reset asserted in WAIT, then rvalid one cycle after reset drops -> response ignored, first request at RESET_PC, inst_valid=0.
